// File: rtl/ddr3_app_arb.sv
// Two-port (writer/reader) round-robin arbiter in front of the MIG DDR3 app port.
// Optional watchdog release is enabled with `define DDR3_APP_ARB_TIMEOUT_EN.
module ddr3_app_arb #(
    parameter int unsigned P_ADDR_W  = 27,
    parameter int unsigned P_DATA_W  = 256,
    parameter int unsigned P_TIMEOUT = 1024
) (
    input  logic                i_ddr3_clk,
    input  logic                i_rst_n,
    input  logic                i_wr_request,
    input  logic                i_rd_request,
    output logic                o_wr_response,
    output logic                o_rd_response,
    input  logic                i_wr_bust_end,
    input  logic                i_rd_bust_end,
    input  logic                i_wr_app_en,
    input  logic [2:0]          i_wr_app_cmd,
    input  logic [P_ADDR_W-1:0] i_wr_addr,
    input  logic                i_wr_wdf_wren,
    input  logic                i_wr_wdf_end,
    input  logic [P_DATA_W-1:0] i_wr_wdf_data,
    input  logic                i_rd_app_en,
    input  logic [2:0]          i_rd_app_cmd,
    input  logic [P_ADDR_W-1:0] i_rd_addr,
    output logic                o_app_en,
    output logic [2:0]          o_app_cmd,
    output logic [P_ADDR_W-1:0] o_addr,
    output logic                o_app_wdf_wren,
    output logic                o_app_wdf_end,
    output logic [P_DATA_W-1:0] o_app_wdf_data,
    output logic [1:0]          o_grant,
    output logic                o_busy,
    output logic                o_timeout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GNT_WR  = 2'd1,
        S_GNT_RD  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_last;      // 1 = reader served last
    logic                  r_armed;     // holds off grants on the first edge after reset
    logic                  r_wr_resp;
    logic                  r_rd_resp;
    logic [2:0]            r_cmd;
    logic [P_ADDR_W-1:0]   r_addr;
    logic                  w_in_grant;
    logic                  w_bust_end;
    logic                  w_wd_fire;

    assign w_in_grant = (r_state == S_GNT_WR) || (r_state == S_GNT_RD);
    assign w_bust_end = ((r_state == S_GNT_WR) && i_wr_bust_end) ||
                        ((r_state == S_GNT_RD) && i_rd_bust_end);

`ifdef DDR3_APP_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout;

    // Counter is zero in the first grant clock; the pulse lands on the clock it reads P_TIMEOUT-1.
    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (!w_in_grant || w_bust_end || w_wd_fire) begin
                r_wd_cnt <= '0;
            end else begin
                r_wd_cnt  <= r_wd_cnt + CNT_W'(1);
                r_timeout <= (r_wd_cnt == CNT_W'(P_TIMEOUT - 2));
            end
        end
    end

    assign w_wd_fire = w_in_grant && (r_wd_cnt == CNT_W'(P_TIMEOUT - 1));
    assign o_timeout = r_timeout;
`else
    assign w_wd_fire = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_last    <= 1'b1;
            r_armed   <= 1'b0;
            r_wr_resp <= 1'b0;
            r_rd_resp <= 1'b0;
            r_cmd     <= 3'd0;
            r_addr    <= '0;
        end else begin
            r_armed   <= 1'b1;
            r_wr_resp <= 1'b0;
            r_rd_resp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_armed) begin
                        if (i_wr_request && (!i_rd_request || r_last)) begin
                            r_state   <= S_GNT_WR;
                            r_wr_resp <= 1'b1;
                            r_last    <= 1'b0;
                        end else if (i_rd_request) begin
                            r_state   <= S_GNT_RD;
                            r_rd_resp <= 1'b1;
                            r_last    <= 1'b1;
                        end
                    end
                end
                S_GNT_WR: begin
                    r_addr <= i_wr_addr;
                    r_cmd  <= i_wr_app_cmd;
                    if (i_wr_bust_end || w_wd_fire) r_state <= S_RELEASE;
                end
                S_GNT_RD: begin
                    r_addr <= i_rd_addr;
                    r_cmd  <= i_rd_app_cmd;
                    if (i_rd_bust_end || w_wd_fire) r_state <= S_RELEASE;
                end
                S_RELEASE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    // App-port mux: zero-latency from the registered state; idle holds the last address/cmd.
    always_comb begin
        o_app_en       = 1'b0;
        o_app_cmd      = r_cmd;
        o_addr         = r_addr;
        o_app_wdf_wren = 1'b0;
        o_app_wdf_end  = 1'b0;
        o_app_wdf_data = '0;
        case (r_state)
            S_GNT_WR: begin
                o_app_en       = i_wr_app_en;
                o_app_cmd      = i_wr_app_cmd;
                o_addr         = i_wr_addr;
                o_app_wdf_wren = i_wr_wdf_wren;
                o_app_wdf_end  = i_wr_wdf_end;
                o_app_wdf_data = i_wr_wdf_data;
            end
            S_GNT_RD: begin
                o_app_en  = i_rd_app_en;
                o_app_cmd = i_rd_app_cmd;
                o_addr    = i_rd_addr;
            end
            default: ;
        endcase
    end

    assign o_wr_response = r_wr_resp;
    assign o_rd_response = r_rd_resp;
    assign o_grant       = {(r_state == S_GNT_RD), (r_state == S_GNT_WR)};
    assign o_busy        = (r_state != S_IDLE);

endmodule
